// File: rtl/common_pkg.sv
// Shared types for the ID-stage forwarding and hazard control.
// Stage records and operand-select encodings used across the pipeline.
package common;

  localparam int REG_ADDR_W   = 5;
  localparam int REG_ADDR_MAX = 8;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    EX_MEM = 2'd1,
    MEM_WB = 2'd2
  } forwarding_type;

  // rd is sized for the widest supported register file
  typedef struct packed {
    logic                    valid;
    logic [REG_ADDR_MAX-1:0] rd;
    logic                    reg_write;
    logic                    mem_read;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  function automatic logic is_producer(stage_rec_t r);
    return r.valid && r.reg_write && (r.rd != '0);
  endfunction

endpackage

// File: rtl/forward_ctrl_fwd_select.sv
// Single-operand forward select: youngest matching producer wins.
// Purely combinational; instantiated once per source operand.
module fwd_select
  import common::*;
(
  input  logic                    uses,
  input  logic [REG_ADDR_MAX-1:0] rs,
  input  stage_rec_t              ex,
  input  stage_rec_t              mem,
  output forwarding_type          sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = is_producer(ex) && (ex.rd == rs);
  assign mem_hit = is_producer(mem) && (mem.rd == rs);

  always_comb begin
    sel = NONE;
    if (uses && ex_hit) begin
      sel = EX_MEM;
    end else if (uses && mem_hit) begin
      sel = MEM_WB;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding select and load-use stall control for a 5-stage pipe.
// Tracks EX/MEM/WB destination records and counts stall cycles.
module forward_ctrl
  import common::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      flush,
  output logic                      stall,
  output forwarding_type            ctrl_forward_left_operand,
  output forwarding_type            ctrl_forward_right_operand,
  output logic                      ex_valid,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  stage_rec_t ex_q;
  stage_rec_t mem_q;
  stage_rec_t wb_q;
  stage_rec_t id_rec;

  forwarding_type left_q;
  forwarding_type right_q;
  forwarding_type left_nxt;
  forwarding_type right_nxt;

  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [REG_ADDR_MAX-1:0] rs1_x;
  logic [REG_ADDR_MAX-1:0] rs2_x;
  logic [REG_ADDR_MAX-1:0] rd_x;
  logic                    load_hit;
  logic                    bubble;

  assign rs1_x = REG_ADDR_MAX'(id_rs1);
  assign rs2_x = REG_ADDR_MAX'(id_rs2);
  assign rd_x  = REG_ADDR_MAX'(id_rd);

  assign id_rec = '{
    valid:     id_valid,
    rd:        rd_x,
    reg_write: id_reg_write,
    mem_read:  id_mem_read
  };

  assign load_hit = is_producer(ex_q) && ex_q.mem_read &&
    ((id_uses_rs1 && rs1_x == ex_q.rd) ||
     (id_uses_rs2 && rs2_x == ex_q.rd));

  // flush squashes ID, so a pending load-use stall is moot
  assign stall  = id_valid && !flush && load_hit;
  assign bubble = stall || flush;

  fwd_select u_left (
    .uses (id_uses_rs1),
    .rs   (rs1_x),
    .ex   (ex_q),
    .mem  (mem_q),
    .sel  (left_nxt)
  );

  fwd_select u_right (
    .uses (id_uses_rs2),
    .rs   (rs2_x),
    .ex   (ex_q),
    .mem  (mem_q),
    .sel  (right_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      left_q  <= NONE;
      right_q <= NONE;
      cnt_q   <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q    <= BUBBLE;
        left_q  <= NONE;
        right_q <= NONE;
      end else begin
        ex_q    <= id_rec;
        left_q  <= left_nxt;
        right_q <= right_nxt;
      end
      if (stall && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign ctrl_forward_left_operand  = left_q;
  assign ctrl_forward_right_operand = right_q;
  assign ex_valid                   = ex_q.valid;
  assign stall_count                = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed scenarios plus randomized traffic
// against a history-based reference model.
module tb_forward_ctrl;
  import common::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk;
  logic           rst;
  logic           id_valid;
  logic [4:0]     id_rs1;
  logic [4:0]     id_rs2;
  logic           id_uses_rs1;
  logic           id_uses_rs2;
  logic [4:0]     id_rd;
  logic           id_reg_write;
  logic           id_mem_read;
  logic           flush;
  logic           stall;
  forwarding_type left_sel;
  forwarding_type right_sel;
  logic           ex_valid;
  logic [CW-1:0]  stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  forward_ctrl #(
    .REG_ADDR_WIDTH (5),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .id_valid                   (id_valid),
    .id_rs1                     (id_rs1),
    .id_rs2                     (id_rs2),
    .id_uses_rs1                (id_uses_rs1),
    .id_uses_rs2                (id_uses_rs2),
    .id_rd                      (id_rd),
    .id_reg_write               (id_reg_write),
    .id_mem_read                (id_mem_read),
    .flush                      (flush),
    .stall                      (stall),
    .ctrl_forward_left_operand  (left_sel),
    .ctrl_forward_right_operand (right_sel),
    .ex_valid                   (ex_valid),
    .stall_count                (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the two most recent instructions that entered EX
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } rec_t;

  rec_t           m_hist[2];
  int             m_cnt;
  forwarding_type m_left;
  forwarding_type m_right;

  function automatic bit prod(rec_t r);
    return r.v && r.rw && r.rd != 0;
  endfunction

  function automatic bit exp_stall();
    bit hit;
    if (rst || !id_valid || flush) return 1'b0;
    hit = (id_uses_rs1 && int'(id_rs1) == m_hist[0].rd) ||
          (id_uses_rs2 && int'(id_rs2) == m_hist[0].rd);
    return prod(m_hist[0]) && m_hist[0].mr && hit;
  endfunction

  function automatic forwarding_type exp_sel(bit uses, int rs);
    if (!uses || rs == 0) return NONE;
    for (int age = 0; age < 2; age++) begin
      if (prod(m_hist[age]) && m_hist[age].rd == rs)
        return (age == 0) ? EX_MEM : MEM_WB;
    end
    return NONE;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m_hist[i] = '{0, 0, 0, 0};
    m_cnt   = 0;
    m_left  = NONE;
    m_right = NONE;
  endtask

  task automatic tick();
    bit             s;
    bit             b;
    rec_t           nr;
    forwarding_type nl;
    forwarding_type nrt;
    s   = exp_stall();
    b   = s || flush;
    nl  = b ? NONE : exp_sel(id_uses_rs1, int'(id_rs1));
    nrt = b ? NONE : exp_sel(id_uses_rs2, int'(id_rs2));
    if (b) nr = '{0, 0, 0, 0};
    else nr = '{id_valid, int'(id_rd), id_reg_write, id_mem_read};
    @(posedge clk);
    m_hist[1] = m_hist[0];
    m_hist[0] = nr;
    m_left    = nl;
    m_right   = nrt;
    if (s && m_cnt < CMAX) m_cnt++;
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1,
                       input int rs2, input bit u2, input int rd,
                       input bit rw, input bit mr, input bit fl);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_uses_rs1  = u1;
    id_rs2       = 5'(rs2);
    id_uses_rs2  = u2;
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  task automatic test_reset();
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset stall: got %0b want 0", stall);
    end
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset ex_valid: got %0b want 0", ex_valid);
    end
    n_checks++;
    if (left_sel !== NONE || right_sel !== NONE) begin
      n_fail++;
      $display("FAIL reset sel: got %0d/%0d want 0/0", left_sel, right_sel);
    end
    n_checks++;
    if (stall_count !== '0) begin
      n_fail++; $display("FAIL reset cnt: got %0d want 0", stall_count);
    end
  endtask

  task automatic test_ex_mem();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    drive(1, 5, 1, 6, 1, 8, 1, 0, 0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL ex_mem stall: got %0b want 0", stall);
    end
    tick();
    n_checks++;
    if (left_sel !== EX_MEM || right_sel !== NONE || ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ex_mem sel: got %0d/%0d v%0b want 1/0 v1",
               left_sel, right_sel, ex_valid);
    end
  endtask

  task automatic test_mem_wb();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 1, 1, 5, 1, 9, 1, 0, 0);
    tick();
    n_checks++;
    if (right_sel !== MEM_WB || left_sel !== NONE) begin
      n_fail++;
      $display("FAIL mem_wb sel: got %0d/%0d want 0/2", left_sel, right_sel);
    end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = m_cnt;
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 7, 1, 0, 0, 10, 1, 0, 0);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL load_use stall: got %0b want 1", stall);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use bubble: got v%0b s%0b want v0 s0",
               ex_valid, stall);
    end
    tick();
    n_checks++;
    if (left_sel !== MEM_WB || ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use left: got %0d v%0b want 2 v1",
               left_sel, ex_valid);
    end
    n_checks++;
    if (stall_count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL load_use cnt: got %0d want %0d", stall_count, c0 + 1);
    end
  endtask

  task automatic test_x0_priority();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 11, 1, 0, 0);
    tick();
    n_checks++;
    if (left_sel !== NONE || right_sel !== NONE) begin
      n_fail++;
      $display("FAIL x0 sel: got %0d/%0d want 0/0", left_sel, right_sel);
    end
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    tick();
    drive(1, 3, 1, 3, 1, 12, 1, 0, 0);
    tick();
    n_checks++;
    if (left_sel !== EX_MEM || right_sel !== EX_MEM) begin
      n_fail++;
      $display("FAIL priority sel: got %0d/%0d want 1/1",
               left_sel, right_sel);
    end
  endtask

  task automatic test_flush();
    int c0;
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    c0 = m_cnt;
    drive(1, 7, 1, 7, 1, 13, 1, 0, 1);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL flush stall: got %0b want 0", stall);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || stall_count !== CW'(c0)) begin
      n_fail++;
      $display("FAIL flush bubble: got v%0b cnt %0d want v0 cnt %0d",
               ex_valid, stall_count, c0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 2; i++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
      tick();
      drive(1, 7, 1, 0, 0, 14, 1, 0, 0);
      tick();
      tick();
      n_checks++;
      if (stall_count !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL sat step %0d: got %0d want %0d",
                 i, stall_count, m_cnt);
      end
    end
    n_checks++;
    if (stall_count !== CW'(CMAX)) begin
      n_fail++;
      $display("FAIL sat hold: got %0d want %0d", stall_count, CMAX);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall()) begin
        drive($urandom_range(0, 7) != 0,
              $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      end
      #1;
      n_checks++;
      if (stall !== exp_stall()) begin
        n_fail++;
        $display("FAIL rand stall @%0d: got %0b want %0b",
                 i, stall, exp_stall());
      end
      tick();
      n_checks++;
      if (ex_valid !== m_hist[0].v || left_sel !== m_left ||
          right_sel !== m_right || stall_count !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand out @%0d: got v%0b %0d/%0d c%0d want v%0b %0d/%0d c%0d",
                 i, ex_valid, left_sel, right_sel, stall_count,
                 m_hist[0].v, m_left, m_right, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
    tick();
    drive(1, 9, 1, 0, 0, 15, 1, 0, 0);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL mid_stall pre: got %0b want 1", stall);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || stall_count !== '0 ||
        left_sel !== NONE || right_sel !== NONE) begin
      n_fail++;
      $display("FAIL mid_stall rst: got s%0b v%0b c%0d %0d/%0d want zeros",
               stall, ex_valid, stall_count, left_sel, right_sel);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL mid_stall post: got %0b want 0", stall);
    end
    tick();
    n_checks++;
    if (left_sel !== NONE || ex_valid !== 1'b1 || stall_count !== '0) begin
      n_fail++;
      $display("FAIL mid_stall resume: got %0d v%0b c%0d want 0 v1 c0",
               left_sel, ex_valid, stall_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_ex_mem();
    test_mem_wb();
    test_load_use();
    test_x0_priority();
    test_flush();
    test_saturation();
    test_random();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register-index width.
REQ-002 Parameter CNT_WIDTH, default 32, stall-counter width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 id_valid  input  1  instruction present in ID.
REQ-006 id_rs1, id_rs2  input  REG_ADDR_WIDTH  ID source register indices.
REQ-007 id_uses_rs1, id_uses_rs2  input  1  ID instruction reads that source.
REQ-008 id_rd  input  REG_ADDR_WIDTH  ID destination index.
REQ-009 id_reg_write, id_mem_read  input  1  ID writes rd; ID is a load.
REQ-010 flush  input  1  squash ID instruction (branch/jump redirect).
REQ-011 stall  output  1  hold PC and IF/ID; combinational.
REQ-012 ctrl_forward_left_operand, ctrl_forward_right_operand  output  forwarding_type  registered operand selects for the instruction in EX.
REQ-013 ex_valid  output  1  registered; EX holds a real (non-bubble) instruction.
REQ-014 stall_count  output  CNT_WIDTH  registered count of load-use stall cycles.

Function
REQ-015 Block shall track three stage records (EX, MEM, WB), each: valid, rd, reg_write, mem_read.
REQ-016 A record shall be a forwarding producer only if valid, reg_write = 1 and rd != 0.
REQ-017 stall shall be 1 when id_valid, flush = 0, EX record is a producer with mem_read = 1, and (id_uses_rs1 and id_rs1 = EX.rd, or id_uses_rs2 and id_rs2 = EX.rd).
REQ-018 Every rising edge: WB <= MEM and MEM <= EX, unconditionally.
REQ-019 EX <= ID fields with valid = id_valid when stall = 0 and flush = 0; otherwise EX <= bubble (valid = 0, reg_write = 0, mem_read = 0).
REQ-020 Left select, registered into EX with the ID instruction: EX_MEM if id_uses_rs1 and current EX is a producer with rd = id_rs1; else MEM_WB if current MEM is a producer with rd = id_rs1; else NONE.
REQ-021 Right select: same rule using id_rs2 and id_uses_rs2.
REQ-022 EX_MEM shall take priority over MEM_WB (youngest producer wins).
REQ-023 On a bubble insert (stall or flush), both selects shall register NONE.
REQ-024 Source index 0 shall never produce a forward select.
REQ-025 flush and stall asserted together: flush wins; stall output = 0; bubble inserted.
REQ-026 Load-use stall shall last exactly one cycle; the held instruction shall then register MEM_WB for the load operand.
REQ-027 stall_count shall increment by 1 each cycle stall = 1 and saturate at all-ones.
REQ-028 ex_valid shall equal EX.valid.

Reset
REQ-029 While rst = 1, all three records invalid, both selects = NONE, ex_valid = 0, stall_count = 0; stall therefore 0.
REQ-030 rst asserted mid-stall shall cancel the stall immediately; after release, the first ID instruction shall proceed with no stall and NONE selects.

Structure
REQ-031 forwarding_type (NONE, EX_MEM, MEM_WB) and the stage-record struct shall live in package common; REG_ADDR_WIDTH default shall come from a common constant.
REQ-032 One sub-module, fwd_select, shall compute a single operand select (combinational) and be instantiated twice.

Verification
REQ-033 Producer then consumer: add x5 in ID, next cycle sub reading rs1 = x5 -> sub enters EX with left = EX_MEM, right = NONE, stall = 0.
REQ-034 Gap of one: add x5, nop, or reading rs2 = x5 -> right = MEM_WB.
REQ-035 Load-use: lw x7, then add reading x7 in rs1 -> stall = 1 for one cycle, EX bubble (ex_valid = 0), next cycle left = MEM_WB, stall_count = 1.
REQ-036 x0 and priority: write x0 then read x0 -> NONE; write x3 twice back-to-back then read x3 -> EX_MEM.
REQ-037 flush with load-use condition present -> stall = 0, EX bubble, stall_count unchanged.
REQ-038 rst pulsed during stall -> outputs at reset values within the same cycle, stall_count = 0 after release; saturation check: preload near all-ones (CNT_WIDTH = 4) -> holds at 15.
